// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: combinational sum/carry/overflow plus a
// registered copy with synchronous active-high reset and load enable.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_s;

  assign half_s = a ^ b;
  assign s      = half_s ^ ci;
  assign co     = (a & b) | (ci & half_s);

endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             EN,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV,
  output logic [WIDTH-1:0] S_Q,
  output logic             CO_Q,
  output logic             OV_Q
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ov_s;

  assign carry_s[0] = CI;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_s[i]),
      .s  (sum_s[i]),
      .co (carry_s[i+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ov_s = carry_s[WIDTH-1] ^ carry_s[WIDTH];

  assign S  = sum_s;
  assign CO = carry_s[WIDTH];
  assign OV = ov_s;

  // Pipeline copy of the result; reset wins over load enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      S_Q  <= {WIDTH{1'b0}};
      CO_Q <= 1'b0;
      OV_Q <= 1'b0;
    end else if (EN) begin
      S_Q  <= sum_s;
      CO_Q <= carry_s[WIDTH];
      OV_Q <= ov_s;
    end else begin
      S_Q  <= S_Q;
      CO_Q <= CO_Q;
      OV_Q <= OV_Q;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random self-checking bench for full_adder at widths 1, 8 and 16.

module tb_full_adder;

  logic clk = 1'b0;
  logic rst, en;

  logic       a1, b1, ci1;
  logic       s1, co1, ov1, sq1, coq1, ovq1;
  logic [7:0] a8, b8, s8, sq8;
  logic       ci8, co8, ov8, coq8, ovq8;
  logic [15:0] a16, b16, s16, sq16;
  logic        ci16, co16, ov16, coq16, ovq16;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u1 (
    .CLK(clk), .RST(rst), .A(a1), .B(b1), .CI(ci1), .EN(en),
    .S(s1), .CO(co1), .OV(ov1), .S_Q(sq1), .CO_Q(coq1), .OV_Q(ovq1));

  full_adder #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .A(a8), .B(b8), .CI(ci8), .EN(en),
    .S(s8), .CO(co8), .OV(ov8), .S_Q(sq8), .CO_Q(coq8), .OV_Q(ovq8));

  full_adder #(.WIDTH(16)) u16 (
    .CLK(clk), .RST(rst), .A(a16), .B(b16), .CI(ci16), .EN(en),
    .S(s16), .CO(co16), .OV(ov16), .S_Q(sq16), .CO_Q(coq16), .OV_Q(ovq16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  logic [1:0]  exp_tab [8];
  logic [2:0]  vec;
  logic [16:0] ref16;
  logic        ref_ov;
  logic [15:0] ra, rb;
  logic        rci;

  initial begin
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1; en = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0;

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      vec = i[2:0];
      {a1, b1, ci1} = vec;
      #5;
      check($sformatf("w1_sum_%0d", i), {62'd0, co1, s1}, {62'd0, exp_tab[i]});
      check($sformatf("w1_ov_%0d", i), {63'd0, ov1}, {63'd0, vec[0] ^ exp_tab[i][1]});
    end

    {a1, b1, ci1} = 3'b110; #5;
    check("w1_ov_110", {63'd0, ov1}, 64'd1);
    {a1, b1, ci1} = 3'b101; #5;
    check("w1_co_101", {63'd0, co1}, 64'd1);
    check("w1_ov_101", {63'd0, ov1}, 64'd0);

    // WIDTH=8 boundary vectors
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; #5;
    check("w8_ff01", {55'd0, ov8, co8, s8}, {55'd0, 1'b0, 1'b1, 8'h00});
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; #5;
    check("w8_7f01", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b0, 8'h80});
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; #5;
    check("w8_8080", {55'd0, ov8, co8, s8}, {55'd0, 1'b1, 1'b1, 8'h00});
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #5;
    check("w8_wrap", {55'd0, ov8, co8, s8}, {55'd0, 1'b0, 1'b1, 8'hFF});

    // WIDTH=16 wrap-around
    a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1; #5;
    check("w16_wrap", {47'd0, ov16, co16, s16}, {47'd0, 1'b0, 1'b1, 16'hFFFF});

    // Registered path: reset, load, hold, reset priority
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("reg_rst_w1", {61'd0, ovq1, coq1, sq1}, 64'd0);
    check("reg_rst_w16", {46'd0, ovq16, coq16, sq16}, 64'd0);

    @(negedge clk); rst = 1'b0; en = 1'b1; {a1, b1, ci1} = 3'b111;
    #1;
    check("comb_unaffected", {62'd0, co1, s1}, {62'd0, 2'b11});
    check("reg_before_edge", {61'd0, ovq1, coq1, sq1}, 64'd0);
    @(posedge clk); #1;
    check("reg_load", {61'd0, ovq1, coq1, sq1}, {61'd0, 3'b011});

    @(negedge clk); en = 1'b0; {a1, b1, ci1} = 3'b000;
    @(posedge clk); #1;
    check("reg_hold", {61'd0, ovq1, coq1, sq1}, {61'd0, 3'b011});
    check("comb_hold", {62'd0, co1, s1}, 64'd0);

    @(negedge clk); rst = 1'b1; en = 1'b1; {a1, b1, ci1} = 3'b111;
    @(posedge clk); #1;
    check("reg_rst_prio", {61'd0, ovq1, coq1, sq1}, 64'd0);

    // WIDTH=16 random against A+B+CI
    @(negedge clk); rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
      a16 = ra; b16 = rb; ci16 = rci;
      ref16  = {1'b0, ra} + {1'b0, rb} + {16'd0, rci};
      ref_ov = (ra[15] == rb[15]) && (ref16[15] != ra[15]);
      #1;
      check("rnd_comb", {46'd0, ov16, co16, s16}, {46'd0, ref_ov, ref16});
      @(posedge clk); #1;
      check("rnd_reg", {46'd0, ovq16, coq16, sq16}, {46'd0, ref_ov, ref16});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
